// File: rtl/muldiv_seq.sv
// Multi-cycle 8-iteration shift-add multiply / restoring divide sequencer with pipeline stall.
// Optional MULDIV_SIGNED_EN: two's-complement operands via magnitude/sign handling.
module muldiv_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   opcode,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic         stall
);

  localparam logic [5:0] OP_MUL = 6'b000010;
  localparam logic [5:0] OP_DIV = 6'b000100;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         op_q, op_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] mpl_q, mpl_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         dz_q, dz_d;
`ifdef MULDIV_SIGNED_EN
  logic         sa_q, sa_d;
  logic         sb_q, sb_d;
`endif

  logic         valid_op_s, is_div_s, accept_s;
  logic [W-1:0] a_mag_s, b_mag_s;
  logic [W:0]   mul_sum_s;
  logic [W:0]   div_sh_s, div_diff_s;
  logic [W-1:0] step_acc_s, step_mpl_s;
  logic [W-1:0] res_hi_s, res_lo_s;

  assign stall = busy_q | accept_s;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dz    = dz_q;

  // Accept decode, one datapath step and next-state selection.
  always_comb begin
    valid_op_s = (opcode == OP_MUL) || (opcode == OP_DIV);
    is_div_s   = (opcode == OP_DIV);
    accept_s   = start && valid_op_s && (state_q != S_RUN);

`ifdef MULDIV_SIGNED_EN
    a_mag_s = a[W-1] ? (~a + 1'b1) : a;
    b_mag_s = b[W-1] ? (~b + 1'b1) : b;
`else
    a_mag_s = a;
    b_mag_s = b;
`endif

    // Multiply: add multiplicand on multiplier LSB, then shift {acc, mpl} right.
    mul_sum_s  = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    // Divide: shift {rem, quo} left, trial-subtract, restore when the borrow is set.
    div_sh_s   = {acc_q, mpl_q[W-1]};
    div_diff_s = div_sh_s - {1'b0, b_q};
    if (op_q) begin
      step_acc_s = div_diff_s[W] ? div_sh_s[W-1:0] : div_diff_s[W-1:0];
      step_mpl_s = {mpl_q[W-2:0], ~div_diff_s[W]};
    end else begin
      step_acc_s = mul_sum_s[W:1];
      step_mpl_s = {mul_sum_s[0], mpl_q[W-1:1]};
    end

`ifdef MULDIV_SIGNED_EN
    if (op_q) begin
      res_lo_s = (sa_q ^ sb_q) ? (~step_mpl_s + 1'b1) : step_mpl_s;
      res_hi_s = sa_q ? (~step_acc_s + 1'b1) : step_acc_s;
    end else if (sa_q ^ sb_q) begin
      {res_hi_s, res_lo_s} = ~{step_acc_s, step_mpl_s} + 1'b1;
    end else begin
      res_hi_s = step_acc_s;
      res_lo_s = step_mpl_s;
    end
`else
    res_hi_s = step_acc_s;
    res_lo_s = step_mpl_s;
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mpl_d   = mpl_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
`ifdef MULDIV_SIGNED_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          op_d  = is_div_s;
          cnt_d = 3'd0;
          acc_d = {W{1'b0}};
          mpl_d = a_mag_s;
          b_d   = b_mag_s;
          dz_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
          sa_d  = a[W-1];
          sb_d  = b[W-1];
`endif
          if (is_div_s && (b == {W{1'b0}})) begin
            state_d = S_DONE;
            hi_d    = a;
            lo_d    = {W{1'b1}};
            dz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = step_acc_s;
        mpl_d = step_mpl_s;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // Sequencer state, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 1'b0;
      acc_q   <= {W{1'b0}};
      mpl_q   <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      hi_q    <= {W{1'b0}};
      lo_q    <= {W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mpl_q   <= mpl_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef MULDIV_SIGNED_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`endif
    end
  end

endmodule
